// File: rtl/frame_decoder_pkg.sv
// rtl/frame_decoder_pkg.sv - shared framing definitions for encoder and decoder
package frame_decoder_pkg;

  typedef enum logic [2:0] {
    IDLE_CNT = 3'd0,
    ARMED    = 3'd1,
    SYNC_CHK = 3'd2,
    LEN      = 3'd3,
    PAYLOAD  = 3'd4
  } state_e;

  localparam int         DEF_MIN_IDLE = 80;
  localparam logic [7:0] DEF_SYNC     = 8'hD5;
  localparam int         DEF_MAX_LEN  = 20;

endpackage

// File: rtl/frame_decoder_bit_deserializer.sv
// rtl/frame_decoder_bit_deserializer.sv - MSB-first shift register and bit counter
module frame_decoder_bit_deserializer (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  input  logic       bit_valid,
  input  logic       clear,
  output logic [7:0] rx_byte,
  output logic       byte_ready
);

  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;

  always_comb begin
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    if (bit_valid) begin
      shift_d = {shift_q[6:0], din};
    end
    // Counter wraps 7 -> 0 so consecutive bytes need no explicit restart.
    if (clear) begin
      bit_cnt_d = 3'd0;
    end else if (bit_valid) begin
      bit_cnt_d = bit_cnt_q + 3'd1;
    end
  end

  assign rx_byte    = {shift_q[6:0], din};
  assign byte_ready = bit_valid && !clear && (bit_cnt_q == 3'd7);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shift_q   <= 8'd0;
      bit_cnt_q <= 3'd0;
    end else begin
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
    end
  end

endmodule

// File: rtl/frame_decoder.sv
// rtl/frame_decoder.sv - serial frame locator delivering payload bytes with sof/eof
module frame_decoder
  import frame_decoder_pkg::*;
#(
  parameter int         MIN_IDLE = DEF_MIN_IDLE,
  parameter logic [7:0] SYNC     = DEF_SYNC,
  parameter int         MAX_LEN  = DEF_MAX_LEN
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       din,
  input  logic       bit_valid,
  output logic [7:0] dout,
  output logic       dout_valid,
  output logic       sof,
  output logic       eof,
  output logic       frame_done,
  output logic       len_err
);

  localparam logic [7:0] MIN_IDLE_B = 8'(MIN_IDLE);
  localparam logic [7:0] MAX_LEN_B  = 8'(MAX_LEN);

  state_e     state_q, state_d;
  logic [7:0] zero_run_q, zero_run_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       first_q, first_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_valid_q, dout_valid_d;
  logic       sof_q, sof_d;
  logic       eof_q, eof_d;
  logic       frame_done_q, frame_done_d;
  logic       len_err_q, len_err_d;

  logic       clear;
  logic [7:0] rx_byte;
  logic       byte_ready;

  frame_decoder_bit_deserializer u_deser (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .bit_valid  (bit_valid),
    .clear      (clear),
    .rx_byte    (rx_byte),
    .byte_ready (byte_ready)
  );

  always_comb begin
    state_d      = state_q;
    zero_run_d   = zero_run_q;
    byte_cnt_d   = byte_cnt_q;
    first_d      = first_q;
    dout_d       = dout_q;
    dout_valid_d = 1'b0;
    sof_d        = 1'b0;
    eof_d        = 1'b0;
    frame_done_d = 1'b0;
    len_err_d    = 1'b0;
    clear        = 1'b0;

    case (state_q)
      IDLE_CNT: begin
        clear = 1'b1;
        if (bit_valid) begin
          if (din) begin
            zero_run_d = 8'd0;
          end else begin
            if (zero_run_q < MIN_IDLE_B) begin
              zero_run_d = zero_run_q + 8'd1;
            end
            if (zero_run_d == MIN_IDLE_B) begin
              state_d = ARMED;
            end
          end
        end
      end
      ARMED: begin
        // The leading 1 of SYNC is counted as bit 1 of the sync window.
        clear = !din;
        if (bit_valid && din) begin
          state_d = SYNC_CHK;
        end
      end
      SYNC_CHK: begin
        if (byte_ready) begin
          if (rx_byte == SYNC) begin
            state_d = LEN;
          end else begin
            state_d    = IDLE_CNT;
            zero_run_d = 8'd0;
          end
        end
      end
      LEN: begin
        if (byte_ready) begin
          if (rx_byte == 8'd0) begin
            frame_done_d = 1'b1;
            state_d      = IDLE_CNT;
            zero_run_d   = 8'd0;
          end else if (rx_byte > MAX_LEN_B) begin
            len_err_d  = 1'b1;
            state_d    = IDLE_CNT;
            zero_run_d = 8'd0;
          end else begin
            byte_cnt_d = rx_byte;
            first_d    = 1'b1;
            state_d    = PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (byte_ready) begin
          dout_d       = rx_byte;
          dout_valid_d = 1'b1;
          sof_d        = first_q;
          first_d      = 1'b0;
          byte_cnt_d   = byte_cnt_q - 8'd1;
          if (byte_cnt_q == 8'd1) begin
            eof_d        = 1'b1;
            frame_done_d = 1'b1;
            state_d      = IDLE_CNT;
            zero_run_d   = 8'd0;
          end
        end
      end
      default: begin
        clear      = 1'b1;
        state_d    = IDLE_CNT;
        zero_run_d = 8'd0;
        byte_cnt_d = 8'd0;
        first_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE_CNT;
      zero_run_q   <= 8'd0;
      byte_cnt_q   <= 8'd0;
      first_q      <= 1'b0;
      dout_q       <= 8'd0;
      dout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      eof_q        <= 1'b0;
      frame_done_q <= 1'b0;
      len_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      zero_run_q   <= zero_run_d;
      byte_cnt_q   <= byte_cnt_d;
      first_q      <= first_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      sof_q        <= sof_d;
      eof_q        <= eof_d;
      frame_done_q <= frame_done_d;
      len_err_q    <= len_err_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign sof        = sof_q;
  assign eof        = eof_q;
  assign frame_done = frame_done_q;
  assign len_err    = len_err_q;

endmodule

// File: tb/tb_frame_decoder.sv
// tb/tb_frame_decoder.sv - scoreboard bench for frame_decoder
module tb_frame_decoder;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       din = 1'b0;
  logic       bit_valid = 1'b0;
  logic [7:0] dout;
  logic       dout_valid, sof, eof, frame_done, len_err;

  frame_decoder dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .din        (din),
    .bit_valid  (bit_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .sof        (sof),
    .eof        (eof),
    .frame_done (frame_done),
    .len_err    (len_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       v, s, e, fd, le;
    int         stamp;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_pass = 0;
  int  n_total = 0;
  int  gap = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s actual=%0h required=%0h", name, act, expv);
  endtask

  // Expected event lands on the negedge following the edge that samples the last driven bit.
  task automatic push(input logic [7:0] d, input logic v, s, e, fd, le);
    ev_t ev;
    ev.d = d; ev.v = v; ev.s = s; ev.e = e; ev.fd = fd; ev.le = le;
    ev.stamp = cyc + 1;
    exp_q.push_back(ev);
  endtask

  always @(negedge clk) begin
    if (reset_n && (dout_valid || frame_done || len_err)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_output", {27'd0, dout_valid, sof, eof, frame_done, len_err}, 32'd0);
      end else begin
        ev_t ev;
        ev = exp_q.pop_front();
        check("event_cycle", cyc, ev.stamp);
        check("event_flags", {27'd0, dout_valid, sof, eof, frame_done, len_err},
              {27'd0, ev.v, ev.s, ev.e, ev.fd, ev.le});
        if (ev.v) check("dout", {24'd0, dout}, {24'd0, ev.d});
      end
    end
  end

  task automatic send_bit(input logic b);
    repeat (gap) begin
      @(posedge clk); #1;
      bit_valid = 1'b0;
      din = 1'($urandom);
    end
    @(posedge clk); #1;
    din = b;
    bit_valid = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) send_bit(1'b0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      bit_valid = 1'b0;
    end
  endtask

  task automatic frame_abc();
    send_zeros(80);
    send_byte(8'hD5);
    send_byte(8'h03);
    send_byte(8'hA1); push(8'hA1, 1, 1, 0, 0, 0);
    send_byte(8'hB2); push(8'hB2, 1, 0, 0, 0, 0);
    send_byte(8'hC3); push(8'hC3, 1, 0, 1, 1, 0);
  endtask

  task automatic check_outputs_zero(input string name);
    check(name, {23'd0, dout, dout_valid, sof, eof, frame_done, len_err}, 32'd0);
  endtask

  initial begin
    #1 reset_n = 1'b0;
    #1 check_outputs_zero("reset_outputs");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Basic three-byte frame.
    frame_abc();
    idle(4);

    // 79 zeros is one short of idle; this frame must be ignored.
    send_zeros(79);
    send_byte(8'hD5); send_byte(8'h03);
    send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3);
    send_zeros(80);
    send_byte(8'hD5); send_byte(8'h02);
    send_byte(8'h11); push(8'h11, 1, 1, 0, 0, 0);
    send_byte(8'h22); push(8'h22, 1, 0, 1, 1, 0);
    idle(4);

    // LENGTH=21 exceeds the limit, then a single-byte frame.
    send_zeros(80);
    send_byte(8'hD5);
    send_byte(8'h15); push(8'h00, 0, 0, 0, 0, 1);
    send_zeros(80);
    send_byte(8'hD5); send_byte(8'h01);
    send_byte(8'h7E); push(8'h7E, 1, 1, 1, 1, 0);
    idle(4);

    // Largest legal length boundary: LENGTH=20 accepted.
    send_zeros(80);
    send_byte(8'hD5); send_byte(8'd20);
    for (int i = 0; i < 20; i++) begin
      send_byte(8'(i * 7 + 3));
      push(8'(i * 7 + 3), 1, (i == 0), (i == 19), (i == 19), 0);
    end
    idle(4);

    // Zero-length frame.
    send_zeros(80);
    send_byte(8'hD5);
    send_byte(8'h00); push(8'h00, 0, 0, 0, 1, 0);
    idle(4);

    // Sparse bit_valid with junk din in the gaps.
    gap = 2;
    frame_abc();
    gap = 0;
    idle(4);

    // Reset mid-payload discards the rest of the frame.
    send_zeros(80);
    send_byte(8'hD5); send_byte(8'h03);
    send_byte(8'hA1); push(8'hA1, 1, 1, 0, 0, 0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    @(posedge clk); #1;
    bit_valid = 1'b0;
    reset_n = 1'b0;
    #1 check_outputs_zero("async_reset_outputs");
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;
    send_zeros(80);
    send_byte(8'hD5); send_byte(8'h01);
    send_byte(8'h5A); push(8'h5A, 1, 1, 1, 1, 0);
    idle(40);

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
